gather_buf: RTL and testbench



---
 rtl/parammod_pkg.sv | 21 ++
 rtl/cnt_bits.sv | 20 ++
 rtl/gather.sv | 37 +++
 rtl/gather_buf.sv | 119 +++++++++++
 tb/tb_gather_buf.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/parammod_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | parammod_pkg : polarity constants and width helper functions      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package parammod_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   // A single-entry buffer still needs one pointer bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_bits.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cnt_bits : population count of a W-bit vector                     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module cnt_bits #(
   parameter int W  = 8,
   parameter int OW = $clog2(W + 1)
) (
   input  logic [W-1:0]  bits,
   output logic [OW-1:0] cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < W; i++) cnt = cnt + OW'(bits[i]);
   end

endmodule
`default_nettype wire

// File: rtl/gather.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gather : packs selected input lanes into consecutive output lanes |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module gather #(
   parameter int DATA   = 32,
   parameter int N_IN   = 8,
   parameter int N_OUT  = 8,
   parameter int OFFSET = 0
) (
   input  logic [N_IN*DATA-1:0]  din,
   input  logic [N_IN-1:0]       sel,
   output logic [N_OUT*DATA-1:0] dout,
   output logic [N_OUT-1:0]      vout
);

   int w_rank;

   // Selected lane i lands at output position OFFSET + (selected lanes below i).
   always_comb begin
      dout   = '0;
      vout   = '0;
      w_rank = OFFSET;
      for (int i = 0; i < N_IN; i++) begin
         for (int o = 0; o < N_OUT; o++) begin
            if (sel[i] && (w_rank == o)) begin
               dout[o*DATA +: DATA] = din[i*DATA +: DATA];
               vout[o]              = 1'b1;
            end
         end
         if (sel[i]) w_rank = w_rank + 1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/gather_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gather_buf : compacting multi-lane FIFO with multi-lane pop       |
// | Optional GATHER_BUF_FLUSH_EN adds a synchronous flush input.      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module gather_buf
   import parammod_pkg::*;
#(
   parameter int   DATA  = 32,
   parameter int   IN    = 8,
   parameter int   OUT   = 4,
   parameter int   DEPTH = 16,
   parameter logic ACT   = ENABLE
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [IN*DATA-1:0]          in,
   input  logic [IN-1:0]               sel,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [OUT*DATA-1:0]         out,
   output logic [OUT-1:0]              out_valid,
   input  logic [cnt_w(OUT)-1:0]       out_pop,
   output logic [cnt_w(DEPTH)-1:0]     count
`ifdef GATHER_BUF_FLUSH_EN
   ,
   input  logic                        flush
`endif
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DATA-1:0]      r_mem [DEPTH];
   logic [PW-1:0]        r_rd_ptr;
   logic [PW-1:0]        r_wr_ptr;
   logic [CW-1:0]        r_count;

   logic [IN-1:0]        w_sel;
   logic [IN*DATA-1:0]   w_gdata;
   logic [IN-1:0]        w_gvalid;
   logic [CW-1:0]        w_nsel;
   logic [CW-1:0]        w_push_n;
   logic [CW-1:0]        w_pop_eff;
   logic                 w_push;
   logic                 w_clear;
   logic                 w_wr_en;

   assign w_sel = (ACT == ENABLE) ? sel : ~sel;

   gather #(
      .DATA   (DATA),
      .N_IN   (IN),
      .N_OUT  (IN),
      .OFFSET (0)
   ) u_gather (
      .din  (in),
      .sel  (w_sel),
      .dout (w_gdata),
      .vout (w_gvalid)
   );

   cnt_bits #(
      .W  (IN),
      .OW (CW)
   ) u_cnt_bits (
      .bits (w_sel),
      .cnt  (w_nsel)
   );

`ifdef GATHER_BUF_FLUSH_EN
   assign w_clear = reset | flush;
`else
   assign w_clear = reset;
`endif

   // Space check uses registered occupancy only, so no pop credit this cycle.
   assign in_ready = (CW'(DEPTH) - r_count) >= w_nsel;
   assign w_push   = in_valid & in_ready;
   assign w_push_n = w_push ? w_nsel : '0;
   assign w_wr_en  = w_push & ~w_clear;

   always_comb begin
      w_pop_eff = CW'(out_pop);
      if (w_pop_eff > r_count) w_pop_eff = r_count;
      if (w_pop_eff > CW'(OUT)) w_pop_eff = CW'(OUT);
   end

   always_ff @(posedge clk) begin
      if (reset || w_clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + PW'(w_pop_eff);
         r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
         r_count  <= r_count + w_push_n - w_pop_eff;
      end
   end

   // Gathered lane j goes to wr_ptr+j; pointer width wraps the index.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int j = 0; j < IN; j++) begin
            if (w_gvalid[j]) r_mem[r_wr_ptr + PW'(j)] <= w_gdata[j*DATA +: DATA];
         end
      end
   end

   for (genvar k = 0; k < OUT; k++) begin : g_out
      assign out_valid[k]         = r_count > CW'(k);
      assign out[k*DATA +: DATA]  = out_valid[k] ? r_mem[r_rd_ptr + PW'(k)] : '0;
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_gather_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_gather_buf : directed and randomized checks of gather_buf      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_gather_buf;

   localparam int DATA  = 32;
   localparam int IN    = 4;
   localparam int OUT   = 2;
   localparam int DEPTH = 8;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 flush = 1'b0;
   logic [IN*DATA-1:0]   din = '0;
   logic [IN-1:0]        sel = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [OUT*DATA-1:0]  dout;
   logic [OUT-1:0]       out_valid;
   logic [1:0]           out_pop = '0;
   logic [3:0]           count;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;
   logic [DATA-1:0] mq[$];

   gather_buf #(
      .DATA  (DATA),
      .IN    (IN),
      .OUT   (OUT),
      .DEPTH (DEPTH),
      .ACT   (1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (din),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (dout),
      .out_valid (out_valid),
      .out_pop   (out_pop),
      .count     (count)
`ifdef GATHER_BUF_FLUSH_EN
      ,
      .flush     (flush)
`endif
   );

   always #5 clk = ~clk;

   function automatic int popc(input logic [IN-1:0] s);
      int n = 0;
      for (int i = 0; i < IN; i++) n += int'(s[i]);
      return n;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the buffer is just an ordered queue of words.
   task automatic model_edge();
      int np;
      if (reset || flush) begin
         mq.delete();
         return;
      end
      np = int'(out_pop);
      if (np > mq.size()) np = mq.size();
      if (np > OUT) np = OUT;
      if (in_valid && (DEPTH - mq.size() >= popc(sel))) begin
         for (int k = 0; k < np; k++) void'(mq.pop_front());
         for (int i = 0; i < IN; i++) if (sel[i]) mq.push_back(din[i*DATA +: DATA]);
      end else begin
         for (int k = 0; k < np; k++) void'(mq.pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         logic [OUT*DATA-1:0] e_out;
         logic [OUT-1:0]      e_v;
         e_out = '0;
         e_v   = '0;
         for (int k = 0; k < OUT; k++) begin
            if (k < mq.size()) begin
               e_v[k] = 1'b1;
               e_out[k*DATA +: DATA] = mq[k];
            end
         end
         check("in_ready", 128'(in_ready), 128'((DEPTH - mq.size()) >= popc(sel)));
         check("count", 128'(count), 128'(mq.size()));
         check("out_valid", 128'(out_valid), 128'(e_v));
         check("out", 128'(dout), 128'(e_out));
      end
   end

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drv(input logic v, input logic [IN-1:0] s, input logic [15:0] tag, input int p);
      in_valid = v;
      sel      = s;
      out_pop  = 2'(p);
      for (int i = 0; i < IN; i++) din[i*DATA +: DATA] = {tag, 16'(i)};
   endtask

   task automatic cyc(input logic v, input logic [IN-1:0] s, input logic [15:0] tag, input int p);
      drv(v, s, tag, p);
      tick();
      drv(1'b0, '0, 16'h0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      drv(1'b0, '0, 16'h0, 0);
      reset = 1'b1;
      tick();
      cmp_en = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_count", 128'(count), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out", 128'(dout), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(1));

      // Lanes {D,C,B,A}, sel 1010 keeps B then D.
      in_valid = 1'b1;
      sel = 4'b1010;
      din = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      tick();
      drv(1'b0, '0, 16'h0, 0);
      check("sel1010_count", 128'(count), 128'(2));
      check("sel1010_out", 128'(dout), 128'({32'hDDDD_0003, 32'hBBBB_0001}));
      check("sel1010_valid", 128'(out_valid), 128'(2'b11));

      // Near-full and full backpressure.
      cyc(1'b1, 4'b1111, 16'h0011, 0);
      cyc(1'b1, 4'b0001, 16'h0012, 0);
      check("fill7_count", 128'(count), 128'(7));
      drv(1'b1, 4'b0011, 16'h0013, 0);
      #1 check("two_at7_ready", 128'(in_ready), 128'(0));
      tick();
      drv(1'b0, '0, 16'h0, 0);
      check("two_at7_count", 128'(count), 128'(7));
      drv(1'b1, 4'b0001, 16'h0014, 0);
      #1 check("one_at7_ready", 128'(in_ready), 128'(1));
      tick();
      drv(1'b0, '0, 16'h0, 0);
      check("full_count", 128'(count), 128'(8));
      drv(1'b1, 4'b0001, 16'h0015, 0);
      #1 check("full_ready", 128'(in_ready), 128'(0));
      drv(1'b1, 4'b0000, 16'h0016, 0);
      #1 check("full_zero_sel_ready", 128'(in_ready), 128'(1));
      tick();
      drv(1'b0, '0, 16'h0, 0);
      check("zero_sel_count", 128'(count), 128'(8));

      // Pop clamp at count 1.
      cyc(1'b0, '0, 16'h0, 2);
      cyc(1'b0, '0, 16'h0, 2);
      cyc(1'b0, '0, 16'h0, 2);
      cyc(1'b0, '0, 16'h0, 1);
      check("pop_to1_count", 128'(count), 128'(1));
      cyc(1'b0, '0, 16'h0, 2);
      check("clamp_count", 128'(count), 128'(0));
      check("clamp_valid", 128'(out_valid), 128'(0));
      check("clamp_out", 128'(dout), 128'(0));

      // Pointer wrap scenarios.
      do_reset();
      cyc(1'b1, 4'b1111, 16'h0001, 0);
      cyc(1'b1, 4'b1111, 16'h0002, 0);
      cyc(1'b0, '0, 16'h0, 2);
      cyc(1'b0, '0, 16'h0, 2);
      cyc(1'b0, '0, 16'h0, 2);
      cyc(1'b1, 4'b1111, 16'h0003, 0);
      check("rd6_count", 128'(count), 128'(6));
      check("rd6_out", 128'(dout), 128'({32'h0002_0003, 32'h0002_0002}));
      cyc(1'b1, 4'b0011, 16'h0004, 2);
      check("pushpop_count", 128'(count), 128'(6));
      check("pushpop_out", 128'(dout), 128'({32'h0003_0001, 32'h0003_0000}));
      cyc(1'b0, '0, 16'h0, 2);
      cyc(1'b0, '0, 16'h0, 2);
      check("wr6_out", 128'(dout), 128'({32'h0004_0001, 32'h0004_0000}));
      cyc(1'b1, 4'b1111, 16'h0005, 0);
      cyc(1'b0, '0, 16'h0, 2);
      check("straddle_lo", 128'(dout), 128'({32'h0005_0001, 32'h0005_0000}));
      cyc(1'b0, '0, 16'h0, 2);
      check("straddle_hi", 128'(dout), 128'({32'h0005_0003, 32'h0005_0002}));

      // Reset wins over a simultaneous push.
      cyc(1'b1, 4'b0111, 16'h0006, 0);
      check("pre_rst_count", 128'(count), 128'(5));
      drv(1'b1, 4'b1111, 16'h0007, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drv(1'b0, '0, 16'h0, 0);
      check("midrst_count", 128'(count), 128'(0));
      check("midrst_out", 128'(dout), 128'(0));
      cyc(1'b1, 4'b0001, 16'h0008, 0);
      check("post_rst_out", 128'(dout), 128'({32'h0, 32'h0008_0000}));
`ifdef GATHER_BUF_FLUSH_EN
      cyc(1'b1, 4'b1111, 16'h0009, 0);
      check("pre_flush_count", 128'(count), 128'(5));
      drv(1'b1, 4'b1111, 16'h000A, 2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drv(1'b0, '0, 16'h0, 0);
      check("flush_count", 128'(count), 128'(0));
      check("flush_valid", 128'(out_valid), 128'(0));
`endif

      // Randomized traffic with shifting pop pressure.
      for (int c = 0; c < 3000; c++) begin
         int phase;
         phase    = (c / 200) % 3;
         reset    = ($urandom_range(0, 149) == 0);
`ifdef GATHER_BUF_FLUSH_EN
         flush    = ($urandom_range(0, 149) == 0);
`endif
         in_valid = ($urandom_range(0, 3) != 0);
         sel      = 4'($urandom);
         din      = {$urandom, $urandom, $urandom, $urandom};
         if (phase == 0)      out_pop = 2'($urandom_range(0, 1));
         else if (phase == 1) out_pop = 2'($urandom_range(0, 3));
         else                 out_pop = 2'($urandom_range(1, 3));
         tick();
      end
      reset = 1'b0;
      flush = 1'b0;
      drv(1'b0, '0, 16'h0, 0);
      tick();
      cmp_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
